spi_rx_ctrl: RTL and testbench
==============================

SPI_RX_CTRL -- requirements
Module: spi_rx_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits per SPI word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth for sclk, cs_n and mosi.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sclk  input  1  raw SPI clock, asynchronous to clk, SPI mode 0.
REQ-006 SHALL have port cs_n  input  1  raw active-low chip select, asynchronous.
REQ-007 SHALL have port mosi  input  1  raw serial data, asynchronous.
REQ-008 SHALL have port rx_data  output  DATA_W  received word, MSB first on wire.
REQ-009 SHALL have port rx_valid  output  1  rx_data holds an unconsumed word.
REQ-010 SHALL have port rx_ready  input  1  consumer accepts word when rx_valid and rx_ready are both high.
REQ-011 SHALL have port overrun  output  1  sticky: a word completed while the holding register was full.
REQ-012 SHALL have port frame_err  output  1  sticky: cs_n rose with a partial word.
REQ-013 SHALL have port clr_err  input  1  clears overrun and frame_err.
REQ-014 SHALL have port busy  output  1  high while in state SHIFT.

Function
REQ-015 SHALL pass sclk, cs_n and mosi through SYNC_STAGES flops each, then one compare flop, producing single-cycle pulses sclk_rise, cs_fall and cs_rise.
REQ-016 SHALL delay mosi by the same total depth so that the sampled bit is the mosi value present at the sclk rising transition.
REQ-017 SHALL implement FSM states IDLE, SHIFT and WAIT_CS.
REQ-018 In IDLE, SHALL clear the bit counter and shift register on cs_fall and go to SHIFT.
REQ-019 In SHIFT, on each sclk_rise, SHALL shift the aligned mosi into the LSB of the shift register and increment the counter.
REQ-020 When the counter reaches DATA_W, SHALL go to WAIT_CS and, in the same cycle, load the word into rx_data and set rx_valid; one-cycle latency from the final sclk_rise pulse to rx_valid.
REQ-021 If rx_valid is high and not being accepted in that cycle when a word completes, SHALL keep the old rx_data, drop the new word and set overrun.
REQ-022 If acceptance and completion occur in the same cycle, SHALL load the new word, hold rx_valid high and leave overrun unchanged.
REQ-023 In WAIT_CS, SHALL ignore sclk_rise; on cs_rise SHALL return to IDLE.
REQ-024 In SHIFT, on cs_rise with counter nonzero, SHALL set frame_err, discard the partial word and return to IDLE.
REQ-025 In SHIFT, on cs_rise with counter zero, SHALL return to IDLE without raising an error.
REQ-026 SHALL clear rx_valid on handshake only when no new word loads in that cycle.
REQ-027 If clr_err and a new error event coincide, the error SHALL win and the flag stays set.
REQ-028 The counter SHALL be $clog2(DATA_W+1) bits wide and SHALL never wrap.
REQ-029 SHALL allow back-to-back frames: cs_fall in the cycle after the return to IDLE is accepted.

Reset
REQ-030 On reset, SHALL set state to IDLE, counter to 0, shift register and rx_data to 0, rx_valid, overrun, frame_err and busy to 0.
REQ-031 On reset, SHALL preset synchronizers to idle levels: sclk 0, cs_n 1, mosi 0; no edge pulses in the first post-reset cycle.
REQ-032 Reset asserted mid-frame SHALL abort it silently, with no frame_err, and the block SHALL wait for a fresh cs_fall.

Structure
REQ-033 Package spi_pkg SHALL hold the FSM state enum (IDLE, SHIFT, WAIT_CS) and the default DATA_W constant.
REQ-034 Synchronizer plus edge pulse generation SHALL be a sub-module spi_sync_edge, instantiated once per line.

Verification
REQ-035 cs_n low, 16 sclk cycles shifting 0xA5C3, cs_n high, rx_ready=1 -> rx_data=0xA5C3, rx_valid pulses one cycle, no flags.
REQ-036 Two frames 0x1234 then 0xBEEF with rx_ready=0 -> rx_data stays 0x1234, overrun=1; clr_err -> overrun=0.
REQ-037 Frame with only 9 sclk rises then cs_n high -> frame_err=1, rx_valid stays 0; next full frame 0x00FF is received correctly.
REQ-038 rx_ready asserted in the exact cycle a second word (0x5555) completes -> rx_data=0x5555, rx_valid stays high, overrun=0.
REQ-039 Reset pulsed after 8 bits, then a full frame 0x8001 -> rx_data=0x8001, frame_err=0.
REQ-040 17 sclk rises in one frame (0xFFFF plus an extra bit) -> rx_data=0xFFFF, extra bit ignored, no error.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI receive controller.
package spi_pkg;

   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      WAIT_CS = 2'd2
   } spi_state_e;

endpackage : spi_pkg

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous line plus a compare flop that
// turns level changes into single-cycle rise/fall pulses.
module spi_sync_edge #(
   parameter int   SYNC_STAGES = 2,
   parameter logic RST_VAL     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   // Shift the raw line through the synchronizer chain; preset to the idle
   // level so no edge pulse fires right after reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q[0] <= din;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  =  sync_q[SYNC_STAGES-1] & ~prev_q;
   assign fall  = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_rx_ctrl.sv
// SPI mode-0 slave receiver: oversamples sclk/cs_n/mosi on clk, assembles
// MSB-first words into a single holding register with valid/ready handoff.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for cs_n to fall
//   SHIFT   | collecting bits on each sclk rise
//   WAIT_CS | word complete, ignoring further clocks until cs_n rises
module spi_rx_ctrl
   import spi_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              overrun,
   output logic              frame_err,
   input  logic              clr_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   spi_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              overrun_q, overrun_d;
   logic              frame_err_q, frame_err_d;

   logic sclk_rise, cs_rise, cs_fall, mosi_s;
   logic word_done, err_frame, set_ovr;
   logic sclk_level_unused, sclk_fall_unused, cs_level_unused;
   logic mosi_rise_unused, mosi_fall_unused;

   // mosi goes through the same depth as sclk, so its level output lines up
   // with the sclk_rise pulse and carries the bit present at the rising edge.
   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .reset(reset), .din(sclk),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .reset(reset), .din(cs_n),
      .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .reset(reset), .din(mosi),
      .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   // State, bit counter, shift register and output holding register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Frame FSM: bit collection, completion and partial-frame detection.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      word_done = 1'b0;
      err_frame = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               cnt_d   = '0;
               shift_d = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // cs_n deassertion takes priority over a coincident clock edge.
            if (cs_rise) begin
               err_frame = (cnt_q != '0);
               cnt_d     = '0;
               shift_d   = '0;
               state_d   = IDLE;
            end else if (sclk_rise) begin
               shift_d = {shift_q[DATA_W-2:0], mosi_s};
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  word_done = 1'b1;
                  state_d   = WAIT_CS;
               end
            end
         end
         WAIT_CS: begin
            if (cs_rise) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Holding register handoff and sticky error flags; a new error beats clr_err.
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      set_ovr    = 1'b0;
      if (word_done) begin
         if (rx_valid_q && !rx_ready) begin
            set_ovr = 1'b1;
         end else begin
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
         end
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end
      overrun_d   = (overrun_q   & ~clr_err) | set_ovr;
      frame_err_d = (frame_err_q & ~clr_err) | err_frame;
   end

   assign rx_data   = rx_data_q;
   assign rx_valid  = rx_valid_q;
   assign overrun   = overrun_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q == SHIFT);

endmodule : spi_rx_ctrl

// File: tb/tb_spi_rx_ctrl.sv
// Directed bench for spi_rx_ctrl: SPI edges are placed on clk negedges so
// the synchronizer latency is deterministic.
module tb_spi_rx_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sclk = 1'b0;
   logic        cs_n = 1'b1;
   logic        mosi = 1'b0;
   logic        rx_ready = 1'b0;
   logic        clr_err = 1'b0;
   logic [15:0] rx_data;
   logic        rx_valid, overrun, frame_err, busy;

   int n_checks = 0;
   int n_pass   = 0;
   int vld_cycles = 0;
   int vld_low    = 0;
   logic [15:0] cap_data = '0;

   spi_rx_ctrl #(.DATA_W(16), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .overrun(overrun), .frame_err(frame_err), .clr_err(clr_err), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid) begin
         vld_cycles++;
         cap_data = rx_data;
      end else begin
         vld_low++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      mosi = b;
      wait_n(3);
      sclk = 1'b1;
      wait_n(4);
      sclk = 1'b0;
   endtask

   task automatic spi_frame(input logic [31:0] word, input int nbits);
      @(negedge clk);
      cs_n = 1'b0;
      wait_n(4);
      for (int i = nbits - 1; i >= 0; i--) send_bit(word[i]);
      wait_n(4);
      cs_n = 1'b1;
      wait_n(8);
   endtask

   task automatic drain();
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] w;
      wait_n(3);
      check("rst_valid", rx_valid, 0);
      check("rst_data", rx_data, 0);
      check("rst_overrun", overrun, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      wait_n(4);

      // Single frame with consumer always ready.
      rx_ready = 1'b1;
      vld_cycles = 0;
      spi_frame(32'hA5C3, 16);
      check("f1_data", cap_data, 16'hA5C3);
      check("f1_valid_cycles", vld_cycles, 1);
      check("f1_valid_now", rx_valid, 0);
      check("f1_overrun", overrun, 0);
      check("f1_frame_err", frame_err, 0);
      rx_ready = 1'b0;

      // Two frames with no consumer: second word dropped, overrun raised.
      spi_frame(32'h1234, 16);
      spi_frame(32'hBEEF, 16);
      check("ovr_data", rx_data, 16'h1234);
      check("ovr_valid", rx_valid, 1);
      check("ovr_flag", overrun, 1);
      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      check("ovr_cleared", overrun, 0);
      drain();
      check("ovr_drained", rx_valid, 0);

      // Partial frame of 9 bits, then a good frame.
      vld_cycles = 0;
      spi_frame(32'h01FF, 9);
      check("ferr_flag", frame_err, 1);
      check("ferr_no_valid", vld_cycles, 0);
      @(negedge clk); clr_err = 1'b1;
      @(negedge clk); clr_err = 1'b0;
      check("ferr_cleared", frame_err, 0);
      spi_frame(32'h00FF, 16);
      check("ferr_next_data", rx_data, 16'h00FF);
      check("ferr_next_valid", rx_valid, 1);
      check("ferr_next_flag", frame_err, 0);
      drain();

      // Handshake in the exact completion cycle of a second word.
      spi_frame(32'h1111, 16);
      check("hs_first_valid", rx_valid, 1);
      vld_low = 0;
      w = 16'h5555;
      @(negedge clk);
      cs_n = 1'b0;
      wait_n(4);
      for (int i = 15; i >= 1; i--) send_bit(w[i]);
      @(negedge clk);
      mosi = w[0];
      wait_n(3);
      sclk = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
      wait_n(4);
      sclk = 1'b0;
      wait_n(4);
      cs_n = 1'b1;
      wait_n(8);
      check("hs_data", rx_data, 16'h5555);
      check("hs_valid", rx_valid, 1);
      check("hs_no_gap", vld_low, 0);
      check("hs_overrun", overrun, 0);
      drain();

      // Reset mid-frame, then a fresh full frame.
      @(negedge clk);
      cs_n = 1'b0;
      wait_n(4);
      for (int i = 0; i < 8; i++) send_bit(i[0]);
      wait_n(2);
      check("mid_busy", busy, 1);
      reset = 1'b1;
      wait_n(2);
      reset = 1'b0;
      check("mid_rst_busy", busy, 0);
      wait_n(2);
      cs_n = 1'b1;
      wait_n(8);
      rx_ready = 1'b1;
      vld_cycles = 0;
      spi_frame(32'h8001, 16);
      rx_ready = 1'b0;
      check("rst_frame_data", cap_data, 16'h8001);
      check("rst_frame_valid_cycles", vld_cycles, 1);
      check("rst_frame_err", frame_err, 0);

      // 17 clock rises: extra bit after completion is ignored.
      spi_frame(32'h1FFFF, 17);
      check("x17_data", rx_data, 16'hFFFF);
      check("x17_valid", rx_valid, 1);
      check("x17_frame_err", frame_err, 0);
      check("x17_overrun", overrun, 0);
      drain();
      check("x17_drained", rx_valid, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_spi_rx_ctrl
